ccff_chain_loader: RTL and testbench

//  Writer side of the configuration-chain (ccff) protocol used by every logical tile.
//  - Takes bitstream words over a valid/ready port and serialises them onto ccff_head, one bit per enabled prog_clk cycle.
//  - Then recirculates the chain (ccff_tail -> ccff_head) for one full rotation, comparing CRC signatures to verify the load.
//  - The chain is not disturbed by verification. Sits between the configuration controller and the tile's ccff_head/ccff_tail pins.

---
 rtl/ccff_chain_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_ccff_chain_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Writer side of a tile configuration chain. Bitstream words arrive on a
// valid/ready port and are serialised LSB-first onto ccff_head. The chain is
// then rotated once (tail fed back into head). A CRC-16 of the loaded bits is
// compared with a CRC-16 of the bits seen at the tail during that rotation.
// After the rotation the chain holds the same contents it had after loading.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    // Word and bit bookkeeping derived from the chain geometry.
    localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int REM_BITS  = CHAIN_LEN % WORD_W;
    localparam int LAST_BITS = (REM_BITS == 0) ? WORD_W : REM_BITS;
    localparam int BCW       = $clog2(CHAIN_LEN + 1);
    localparam int WCW       = $clog2(WORDS + 1);
    localparam int NCW       = $clog2(WORD_W + 1);

    localparam logic [BCW-1:0] BIT_LAST   = BCW'(CHAIN_LEN - 1);
    localparam logic [BCW-1:0] BIT_ONE    = BCW'(1);
    localparam logic [WCW-1:0] WORD_LAST  = WCW'(WORDS - 1);
    localparam logic [WCW-1:0] WORD_ALL   = WCW'(WORDS);
    localparam logic [WCW-1:0] WORD_ONE   = WCW'(1);
    localparam logic [NCW-1:0] CNT_FULL   = NCW'(WORD_W);
    localparam logic [NCW-1:0] CNT_LAST   = NCW'(LAST_BITS);
    localparam logic [NCW-1:0] CNT_ONE    = NCW'(1);
    localparam logic [15:0]    CRC_INIT   = 16'hFFFF;
    localparam logic [15:0]    CRC_POLY   = 16'h1021;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Serial CRC-16 step, MSB-first, no reflection.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        crc16_step = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_armed;
    logic [WORD_W-1:0] r_buf;
    logic [NCW-1:0]   r_buf_cnt;
    logic [WCW-1:0]   r_word_cnt;
    logic [BCW-1:0]   r_bit_cnt;
    logic [15:0]      r_crc_load;
    logic [15:0]      r_crc_chk;
    logic             r_head_last;

    logic             w_load_shift;
    logic             w_verify_shift;
    logic             w_words_left;
    logic             w_buf_draining;
    logic             w_accept;
    logic             w_start_ok;
    logic             w_last_bit;
    logic [15:0]      w_crc_chk_next;

    // Handshake, shift enable and serial head are combinational so that a word
    // accepted at the end of one cycle starts shifting in the very next cycle,
    // and so that the tail is fed straight back to the head while verifying.
    assign w_load_shift   = (r_state == ST_LOAD) && (r_buf_cnt != '0);
    assign w_verify_shift = (r_state == ST_VERIFY);
    assign w_words_left   = (r_word_cnt != WORD_ALL);
    assign w_buf_draining = (r_buf_cnt == '0) || (r_buf_cnt == CNT_ONE);
    assign s_ready        = (r_state == ST_LOAD) && w_buf_draining && w_words_left;
    assign w_accept       = s_valid && s_ready;
    // start is only honoured once a clock edge has been seen after reset release.
    assign w_start_ok     = (r_state == ST_IDLE) && start && !abort && r_armed;
    assign w_last_bit     = (r_bit_cnt == BIT_LAST);
    assign w_crc_chk_next = crc16_step(r_crc_chk, ccff_tail);

    assign ccff_shift_en  = w_load_shift || w_verify_shift;
    assign ccff_head      = w_verify_shift ? ccff_tail :
                            (w_load_shift  ? r_buf[0]  : r_head_last);

    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_pass;

    // Arm start acceptance one edge after reset is released.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Control FSM with registered busy/done/pass.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_pass <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (w_start_ok) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_shift && w_last_bit) begin
                        r_state <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (w_last_bit) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_pass  <= (w_crc_chk_next == r_crc_load);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Word buffer: load on handshake (only the used bits of the final word
    // are counted), otherwise shift right one bit per load shift.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_buf     <= '0;
            r_buf_cnt <= '0;
        end else if (abort) begin
            r_buf_cnt <= '0;
        end else if (w_accept) begin
            r_buf     <= s_data;
            r_buf_cnt <= (r_word_cnt == WORD_LAST) ? CNT_LAST : CNT_FULL;
        end else if (w_load_shift) begin
            r_buf     <= r_buf >> 1;
            r_buf_cnt <= r_buf_cnt - CNT_ONE;
        end
    end

    // Count words accepted in the current load.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_word_cnt <= '0;
        end else if (abort || w_start_ok) begin
            r_word_cnt <= '0;
        end else if (w_accept) begin
            r_word_cnt <= r_word_cnt + WORD_ONE;
        end
    end

    // Bit counter: cleared entering LOAD and again entering VERIFY.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_bit_cnt <= '0;
        end else if (abort || w_start_ok) begin
            r_bit_cnt <= '0;
        end else if (w_load_shift || w_verify_shift) begin
            if (w_last_bit) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end
        end
    end

    // Signatures: head bits during LOAD, tail bits during VERIFY.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_crc_load <= CRC_INIT;
            r_crc_chk  <= CRC_INIT;
        end else if (w_start_ok) begin
            r_crc_load <= CRC_INIT;
            r_crc_chk  <= CRC_INIT;
        end else begin
            if (w_load_shift) begin
                r_crc_load <= crc16_step(r_crc_load, r_buf[0]);
            end
            if (w_verify_shift) begin
                r_crc_chk <= w_crc_chk_next;
            end
        end
    end

    // Remember the last bit driven so the head holds steady while stalled.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            r_head_last <= 1'b0;
        end else if (w_load_shift || w_verify_shift) begin
            r_head_last <= ccff_head;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a behavioural chain model on
// ccff_head/ccff_tail, a word source and a scoreboard of expected head bits.
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 20;
    localparam int WORD_W    = 8;
    localparam int WORDS     = 3;
    localparam int LAST_BITS = 4;

    logic                 prog_clk = 1'b0;
    logic                 pReset   = 1'b0;
    logic                 start    = 1'b0;
    logic                 abort    = 1'b0;
    logic [WORD_W-1:0]    s_data   = '0;
    logic                 s_valid  = 1'b0;
    logic                 s_ready;
    logic                 ccff_head;
    logic                 ccff_tail;
    logic                 ccff_shift_en;
    logic                 busy;
    logic                 done;
    logic                 pass;

    logic [CHAIN_LEN-1:0] chain      = '0;
    logic [CHAIN_LEN-1:0] stuck_mask = '0;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    ccff_chain_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .ccff_shift_en(ccff_shift_en),
        .busy         (busy),
        .done         (done),
        .pass         (pass)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: shift head in on enabled edges; stuck bits forced to 0.
    assign ccff_tail = chain[CHAIN_LEN-1];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain <= {chain[CHAIN_LEN-2:0], ccff_head} & ~stuck_mask;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
        logic [15:0] r;
        r = {c[14:0], 1'b0};
        if (c[15] != d) r = r ^ 16'h1021;
        return r;
    endfunction

    // Drive one operation cycle by cycle. Cycle 0 is the cycle start is
    // sampled in. Head bits are scoreboarded; other results are returned.
    task automatic run_transfer(
        input  logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
        input  int stall_start, input int stall_len,
        input  int abort_cyc,   input int extra_start_cyc,
        output int done_cyc, output logic pass_v, output logic pass_model,
        output int n_load, output int n_stall);
        logic [7:0]  words [3];
        int          src, cyc, n_used, post;
        int          hold_bad, vhead_bad, ready_bad;
        logic [15:0] crc_l, crc_t;
        logic        last_head, aborted;
        bit          e;
        words[0] = w0; words[1] = w1; words[2] = w2;
        exp_q.delete();
        src = 0; done_cyc = -1; pass_v = 1'b0; n_load = 0; n_stall = 0;
        post = 0; hold_bad = 0; vhead_bad = 0; ready_bad = 0;
        crc_l = 16'hFFFF; crc_t = 16'hFFFF; last_head = 1'b0; aborted = 1'b0;
        @(posedge prog_clk); #1;
        cyc = 0;
        start = 1'b1; abort = (abort_cyc == 0);
        s_valid = 1'b1; s_data = words[0];
        while (cyc < 200) begin
            @(negedge prog_clk);
            if (ccff_shift_en && !aborted) begin
                if (n_load < CHAIN_LEN) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL load_underrun: shift %0d with no expected bit queued", n_load);
                    end else begin
                        e = exp_q.pop_front();
                        crc_l = crc_step(crc_l, e);
                        if (ccff_head !== e) begin
                            errors++;
                            $display("FAIL head_bit[%0d]: got %0b want %0b", n_load, ccff_head, e);
                        end
                    end
                    n_load++;
                    last_head = ccff_head;
                end else begin
                    crc_t = crc_step(crc_t, ccff_tail);
                    if (ccff_head !== ccff_tail) vhead_bad++;
                end
            end else if (!aborted && n_load > 0 && n_load < CHAIN_LEN) begin
                n_stall++;
                if (ccff_head !== last_head) hold_bad++;
            end
            if (n_load == CHAIN_LEN && s_ready) ready_bad++;
            if (aborted && post == 1) begin
                checks++;
                if (busy !== 1'b0 || ccff_shift_en !== 1'b0 || s_ready !== 1'b0 || pass !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_idle: busy=%0b shift_en=%0b s_ready=%0b pass=%0b want all 0",
                             busy, ccff_shift_en, s_ready, pass);
                end
            end
            if (done === 1'b1 && done_cyc < 0) begin
                done_cyc = cyc;
                pass_v   = pass;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || pass !== pass_v) begin
                    errors++;
                    $display("FAIL done_pulse: after done got done=%0b busy=%0b pass=%0b want 0 0 %0b",
                             done, busy, pass, pass_v);
                end
                break;
            end
            if (s_valid && s_ready && !aborted) begin
                if (!abort) begin
                    n_used = (src == WORDS - 1) ? LAST_BITS : WORD_W;
                    for (int i = 0; i < n_used; i++) exp_q.push_back(words[src][i]);
                end
                src++;
            end
            if (abort) begin
                aborted = 1'b1;
                exp_q.delete();
                src = WORDS;
            end
            if (aborted) begin
                post++;
                if (post > 6) break;
            end
            @(posedge prog_clk); #1;
            cyc++;
            start   = (cyc == extra_start_cyc);
            abort   = (cyc == abort_cyc);
            s_valid = (src < WORDS) && !(cyc >= stall_start && cyc < stall_start + stall_len);
            s_data  = (src < WORDS) ? words[src] : '0;
        end
        start = 1'b0; abort = 1'b0; s_valid = 1'b0;
        pass_model = (crc_t == crc_l);
        checks++;
        if (!aborted && done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within 200 cycles");
        end
        checks++;
        if (hold_bad != 0 || vhead_bad != 0 || ready_bad != 0) begin
            errors++;
            $display("FAIL stream_rules: head_moved_in_stall=%0d head_not_tail=%0d ready_in_verify=%0d want 0 0 0",
                     hold_bad, vhead_bad, ready_bad);
        end
        $display("xfer %h %h %h: load_shifts=%0d stalls=%0d done_cyc=%0d pass=%0b model_pass=%0b",
                 w0, w1, w2, n_load, n_stall, done_cyc, pass_v, pass_model);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        checks++;
        if ({busy, done, pass, s_ready, ccff_shift_en, ccff_head} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {busy, done, pass, s_ready, ccff_shift_en, ccff_head});
        end
        @(posedge prog_clk); #1;
        pReset = 1'b1;
        repeat (2) @(posedge prog_clk);
        @(negedge prog_clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy=%0b done=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic_load();
        int dc, nl, ns; logic pv, pm;
        run_transfer(8'hA5, 8'h3C, 8'h0F, -1, 0, -1, -1, dc, pv, pm, nl, ns);
        checks++; if (dc != 42) begin errors++; $display("FAIL basic_done_cycle: got %0d want 42", dc); end
        checks++; if (pv !== 1'b1) begin errors++; $display("FAIL basic_pass: got %0b want 1", pv); end
        checks++; if (pv !== pm) begin errors++; $display("FAIL basic_pass_model: got %0b want %0b", pv, pm); end
        checks++; if (nl != CHAIN_LEN || ns != 0) begin
            errors++; $display("FAIL basic_shifts: loads=%0d stalls=%0d want 20 0", nl, ns);
        end
    endtask

    task automatic test_stall();
        int dc, nl, ns; logic pv, pm;
        run_transfer(8'hA5, 8'h3C, 8'h0F, 17, 5, -1, -1, dc, pv, pm, nl, ns);
        checks++; if (dc != 47) begin errors++; $display("FAIL stall_done_cycle: got %0d want 47", dc); end
        checks++; if (ns != 5) begin errors++; $display("FAIL stall_cycles: got %0d want 5", ns); end
        checks++; if (nl != CHAIN_LEN) begin errors++; $display("FAIL stall_loads: got %0d want 20", nl); end
        checks++; if (pv !== 1'b1 || pv !== pm) begin
            errors++; $display("FAIL stall_pass: got %0b want 1 (model %0b)", pv, pm);
        end
    endtask

    task automatic test_stuck_bit();
        int dc, nl, ns; logic pv, pm;
        stuck_mask = '0;
        stuck_mask[7] = 1'b1;
        run_transfer(8'hFF, 8'hFF, 8'hFF, -1, 0, -1, -1, dc, pv, pm, nl, ns);
        stuck_mask = '0;
        checks++; if (dc != 42) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 42", dc); end
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %0b want 0", pv); end
        checks++; if (pv !== pm) begin errors++; $display("FAIL stuck_pass_model: got %0b want %0b", pv, pm); end
    endtask

    task automatic test_abort();
        int dc, nl, ns; logic pv, pm;
        run_transfer(8'hA5, 8'h3C, 8'h0F, -1, 0, 11, -1, dc, pv, pm, nl, ns);
        checks++; if (dc != -1) begin errors++; $display("FAIL abort_no_done: done at cycle %0d want none", dc); end
        checks++; if (nl != 10) begin errors++; $display("FAIL abort_loads: got %0d want 10", nl); end
        run_transfer(8'h5A, 8'hC3, 8'h09, -1, 0, -1, -1, dc, pv, pm, nl, ns);
        checks++; if (dc != 42 || pv !== 1'b1 || nl != CHAIN_LEN) begin
            errors++; $display("FAIL abort_reload: done_cyc=%0d pass=%0b loads=%0d want 42 1 20", dc, pv, nl);
        end
    endtask

    task automatic test_reset_mid_verify();
        @(posedge prog_clk); #1;
        start = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
        @(posedge prog_clk); #1;
        start = 1'b0;
        repeat (28) @(posedge prog_clk);
        #1;
        checks++;
        if (busy !== 1'b1 || ccff_shift_en !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL verify_phase: busy=%0b shift_en=%0b s_ready=%0b want 1 1 0", busy, ccff_shift_en, s_ready);
        end
        #2;
        pReset = 1'b0;
        #1;
        checks++;
        if ({busy, done, pass, s_ready, ccff_shift_en, ccff_head} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b want 000000",
                     {busy, done, pass, s_ready, ccff_shift_en, ccff_head});
        end
        s_valid = 1'b0;
        @(posedge prog_clk); #1;
        pReset = 1'b1;
        start  = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL start_at_release: cycle %0d busy=%0b want 0", i, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dc, nl, ns; logic pv, pm;
        run_transfer(8'hA5, 8'h3C, 8'h0F, -1, 0, -1, 5, dc, pv, pm, nl, ns);
        checks++; if (dc != 42 || pv !== 1'b1 || nl != CHAIN_LEN) begin
            errors++; $display("FAIL start_in_load: done_cyc=%0d pass=%0b loads=%0d want 42 1 20", dc, pv, nl);
        end
        @(posedge prog_clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge prog_clk);
            checks++;
            if (busy !== 1'b0 || s_ready !== 1'b0 || ccff_shift_en !== 1'b0) begin
                errors++;
                $display("FAIL start_abort_idle: cycle %0d busy=%0b s_ready=%0b shift_en=%0b want 0 0 0",
                         i, busy, s_ready, ccff_shift_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_stuck_bit();
        test_abort();
        test_reset_mid_verify();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
